// File: rtl/calc_op_sequencer.sv
// Calculator operation sequencer: debounces the four op buttons, latches operands,
// runs one start/done transaction on the shared ALU and holds the result for display.
module calc_op_sequencer #(
  parameter int DEB_CYCLES     = 250000,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int OPW            = 8,
  parameter int RESW           = 14
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      op_btn,
  input  logic [OPW-1:0]  operand_a,
  input  logic [OPW-1:0]  operand_b,
  output logic            alu_start,
  output logic [1:0]      alu_op,
  output logic [OPW-1:0]  alu_a,
  output logic [OPW-1:0]  alu_b,
  input  logic            alu_done,
  input  logic [RESW-1:0] alu_result,
  output logic [RESW-1:0] res,
  output logic            res_valid,
  output logic            err,
  output logic            disp_sel,
  output logic            busy
);

  localparam int DCW = $clog2(DEB_CYCLES + 1);
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_SHOW,
    S_ERR
  } state_t;

  state_t state, state_n;

  logic [3:0]     sync1, sync2, deb, deb_d;
  logic [DCW-1:0] dcnt [4];
  logic [3:0]     press;
  logic           press_any;
  logic [1:0]     press_op;
  logic           latch;
  state_t         press_to;
  logic [TCW-1:0] tcnt;

  // Level is accepted only after DEB_CYCLES consecutive samples differ from it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_d <= '0;
      for (int unsigned i = 0; i < 4; i++) dcnt[i] <= '0;
    end else begin
      sync1 <= op_btn;
      sync2 <= sync1;
      deb_d <= deb;
      for (int unsigned i = 0; i < 4; i++) begin
        if (sync2[i] == deb[i]) begin
          dcnt[i] <= '0;
        end else if (dcnt[i] == DCW'(DEB_CYCLES - 1)) begin
          deb[i]  <= sync2[i];
          dcnt[i] <= '0;
        end else begin
          dcnt[i] <= dcnt[i] + 1'b1;
        end
      end
    end
  end

  assign press     = deb & ~deb_d;
  assign press_any = |press;

  always_comb begin
    press_op = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (press[i]) press_op = 2'(i);
    end
  end

  assign press_to = (press_op == 2'd3 && operand_b == '0) ? S_ERR : S_ISSUE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    latch   = 1'b0;
    case (state)
      S_IDLE: begin
        if (press_any) begin
          latch   = 1'b1;
          state_n = press_to;
        end
      end
      S_ISSUE: state_n = S_WAIT;
      S_WAIT: begin
        if (alu_done)                               state_n = S_SHOW;
        else if (tcnt == TCW'(TIMEOUT_CYCLES - 1)) state_n = S_ERR;
      end
      S_SHOW, S_ERR: begin
        if (press_any) begin
          latch   = 1'b1;
          state_n = press_to;
        end else if (operand_a != alu_a || operand_b != alu_b) begin
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_op    <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      res       <= '0;
      res_valid <= 1'b0;
      tcnt      <= '0;
    end else begin
      res_valid <= 1'b0;
      if (latch) begin
        alu_op <= press_op;
        alu_a  <= operand_a;
        alu_b  <= operand_b;
      end
      if (state == S_ISSUE)     tcnt <= '0;
      else if (state == S_WAIT) tcnt <= tcnt + 1'b1;
      if (state == S_WAIT && alu_done) begin
        res       <= alu_result;
        res_valid <= 1'b1;
      end
    end
  end

  assign alu_start = (state == S_ISSUE);
  assign busy      = (state == S_ISSUE) || (state == S_WAIT);
  assign disp_sel  = (state == S_SHOW) || (state == S_ERR);
  assign err       = (state == S_ERR);

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Scoreboard bench for calc_op_sequencer with a small ALU model answering 3 cycles
// after each start (or never, when alu_en is cleared).
module tb_calc_op_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  op_btn;
  logic [7:0]  operand_a, operand_b;
  logic        alu_start;
  logic [1:0]  alu_op;
  logic [7:0]  alu_a, alu_b;
  logic        alu_done;
  logic [13:0] alu_result;
  logic [13:0] res;
  logic        res_valid, err, disp_sel, busy;

  typedef struct packed {
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
  } start_t;

  start_t      sq[$];
  logic [13:0] rq[$];
  int total = 0;
  int bad = 0;
  int n_start = 0;
  int n_resv = 0;
  bit alu_en = 1'b1;
  int cd = 0;
  logic [13:0] pend;

  calc_op_sequencer #(
    .DEB_CYCLES(4),
    .TIMEOUT_CYCLES(16),
    .OPW(8),
    .RESW(14)
  ) dut (
    .clk(clk), .rst(rst), .op_btn(op_btn),
    .operand_a(operand_a), .operand_b(operand_b),
    .alu_start(alu_start), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_done(alu_done), .alu_result(alu_result),
    .res(res), .res_valid(res_valid), .err(err), .disp_sel(disp_sel), .busy(busy)
  );

  always #5 clk = ~clk;

  // ALU model: done exactly 3 cycles after the start cycle
  always @(posedge clk) begin
    alu_done <= 1'b0;
    if (cd != 0) begin
      cd = cd - 1;
      if (cd == 0) begin
        alu_done   <= 1'b1;
        alu_result <= pend;
      end
    end
    if (alu_start && alu_en) begin
      cd = 3;
      case (alu_op)
        2'd0: pend = 14'(alu_a + alu_b);
        2'd1: pend = 14'(alu_a - alu_b);
        2'd2: pend = 14'(alu_a * alu_b);
        default: pend = (alu_b != 0) ? 14'(alu_a / alu_b) : 14'd0;
      endcase
    end
  end

  // Scoreboard: pop expectations as the DUT produces starts and results
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (alu_start) begin
        n_start++;
        total++;
        if (sq.size() == 0) begin
          bad++;
          $display("FAIL unexpected_start got op=%0d a=%0d b=%0d want no start", alu_op, alu_a, alu_b);
        end else begin
          start_t e;
          e = sq.pop_front();
          if ({alu_op, alu_a, alu_b} !== e) begin
            bad++;
            $display("FAIL start_fields got op=%0d a=%0d b=%0d want op=%0d a=%0d b=%0d",
                     alu_op, alu_a, alu_b, e.op, e.a, e.b);
          end
        end
      end
      if (res_valid) begin
        n_resv++;
        total++;
        if (rq.size() == 0) begin
          bad++;
          $display("FAIL unexpected_res_valid got res=%0d want no pulse", res);
        end else begin
          logic [13:0] r;
          r = rq.pop_front();
          if (res !== r || disp_sel !== 1'b1) begin
            bad++;
            $display("FAIL result got res=%0d disp_sel=%0b want res=%0d disp_sel=1", res, disp_sel, r);
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_res(input int target, input int budget);
    int k = 0;
    while (n_resv < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    total++;
    if (n_resv < target) begin
      bad++;
      $display("FAIL res_wait got res_valid count=%0d want %0d", n_resv, target);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    op_btn = '0;
    operand_a = '0;
    operand_b = '0;
    @(negedge clk);
    total++;
    if ({alu_start, alu_op, alu_a, alu_b, res, res_valid, err, disp_sel, busy} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got start=%0b op=%0d a=%0d b=%0d res=%0d rv=%0b err=%0b ds=%0b busy=%0b want all 0",
               alu_start, alu_op, alu_a, alu_b, res, res_valid, err, disp_sel, busy);
    end
    rst = 1'b0;
    tick(2);
    total++;
    if (disp_sel !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL after_reset got disp_sel=%0b busy=%0b want 0 0", disp_sel, busy);
    end
  endtask

  task automatic test_add();
    int s0, r0;
    operand_a = 8'd12;
    operand_b = 8'd34;
    tick(2);
    s0 = n_start;
    r0 = n_resv;
    sq.push_back('{2'd0, 8'd12, 8'd34});
    rq.push_back(14'd46);
    op_btn[0] = 1'b1;
    tick(10);
    op_btn = '0;
    wait_res(r0 + 1, 40);
    tick(10);
    total++;
    if (n_start !== s0 + 1 || n_resv !== r0 + 1) begin
      bad++;
      $display("FAIL add_counts got starts=%0d pulses=%0d want 1 1", n_start - s0, n_resv - r0);
    end
    total++;
    if (res !== 14'd46 || disp_sel !== 1'b1 || err !== 1'b0) begin
      bad++;
      $display("FAIL add_show got res=%0d ds=%0b err=%0b want 46 1 0", res, disp_sel, err);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    total++;
    if ({alu_start, alu_op, alu_a, alu_b, res, res_valid, err, disp_sel, busy} !== '0) begin
      bad++;
      $display("FAIL async_reset got op=%0d a=%0d b=%0d res=%0d err=%0b ds=%0b busy=%0b want all 0",
               alu_op, alu_a, alu_b, res, err, disp_sel, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    tick(2);
    total++;
    if (disp_sel !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL async_release got disp_sel=%0b busy=%0b want 0 0", disp_sel, busy);
    end
  endtask

  task automatic test_mul_bounce();
    int s0, r0;
    s0 = n_start;
    r0 = n_resv;
    sq.push_back('{2'd2, 8'd12, 8'd34});
    rq.push_back(14'd408);
    op_btn[2] = 1'b1; tick(1);
    op_btn[2] = 1'b0; tick(1);
    op_btn[2] = 1'b1; tick(12);
    op_btn = '0;
    wait_res(r0 + 1, 40);
    tick(10);
    total++;
    if (n_start !== s0 + 1 || res !== 14'd408) begin
      bad++;
      $display("FAIL mul_bounce got starts=%0d res=%0d want 1 408", n_start - s0, res);
    end
  endtask

  task automatic test_div_zero();
    int s0;
    operand_b = 8'd0;
    tick(2);
    total++;
    if (disp_sel !== 1'b0) begin
      bad++;
      $display("FAIL operand_change got disp_sel=%0b want 0", disp_sel);
    end
    s0 = n_start;
    op_btn[3] = 1'b1;
    tick(12);
    op_btn = '0;
    tick(8);
    total++;
    if (n_start !== s0 || err !== 1'b1 || disp_sel !== 1'b1 || busy !== 1'b0 || res !== 14'd408) begin
      bad++;
      $display("FAIL div_zero got starts=%0d err=%0b ds=%0b busy=%0b res=%0d want 0 1 1 0 408",
               n_start - s0, err, disp_sel, busy, res);
    end
    operand_b = 8'd5;
    @(negedge clk);
    total++;
    if (err !== 1'b0 || disp_sel !== 1'b0) begin
      bad++;
      $display("FAIL err_clear got err=%0b disp_sel=%0b want 0 0", err, disp_sel);
    end
  endtask

  task automatic test_back_to_back();
    int s0, r0;
    operand_a = 8'd20;
    operand_b = 8'd5;
    tick(2);
    s0 = n_start;
    r0 = n_resv;
    sq.push_back('{2'd1, 8'd20, 8'd5});
    rq.push_back(14'd15);
    op_btn = 4'b1010;
    tick(2);
    op_btn[0] = 1'b1;
    tick(10);
    op_btn = '0;
    wait_res(r0 + 1, 40);
    tick(20);
    total++;
    if (n_start !== s0 + 1 || res !== 14'd15 || disp_sel !== 1'b1) begin
      bad++;
      $display("FAIL arb_wait_press got starts=%0d res=%0d ds=%0b want 1 15 1", n_start - s0, res, disp_sel);
    end
  endtask

  task automatic test_timeout();
    int k, s0;
    bit seen;
    alu_en = 1'b0;
    operand_a = 8'd3;
    operand_b = 8'd4;
    tick(2);
    sq.push_back('{2'd0, 8'd3, 8'd4});
    op_btn[0] = 1'b1;
    seen = 1'b0;
    k = 0;
    while (!seen && k < 30) begin
      @(negedge clk);
      k++;
      if (alu_start === 1'b1) seen = 1'b1;
    end
    op_btn = '0;
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL timeout_start got no alu_start want one within 30 cycles");
    end
    tick(16);
    total++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL timeout_early got err=%0b busy=%0b want 0 1", err, busy);
    end
    @(negedge clk);
    total++;
    if (err !== 1'b1 || busy !== 1'b0 || disp_sel !== 1'b1) begin
      bad++;
      $display("FAIL timeout_err got err=%0b busy=%0b ds=%0b want 1 0 1", err, busy, disp_sel);
    end

    operand_a = 8'd5;
    tick(2);
    sq.push_back('{2'd0, 8'd5, 8'd4});
    op_btn[0] = 1'b1;
    seen = 1'b0;
    k = 0;
    while (!seen && k < 30) begin
      @(negedge clk);
      k++;
      if (alu_start === 1'b1) seen = 1'b1;
    end
    op_btn = '0;
    tick(2);
    s0 = n_start;
    total++;
    if (!seen || busy !== 1'b1) begin
      bad++;
      $display("FAIL rerun_wait got seen=%0b busy=%0b want 1 1", seen, busy);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({alu_start, alu_op, alu_a, alu_b, res, res_valid, err, disp_sel, busy} !== '0) begin
      bad++;
      $display("FAIL wait_reset got a=%0d b=%0d err=%0b ds=%0b busy=%0b want all 0",
               alu_a, alu_b, err, disp_sel, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    tick(40);
    total++;
    if (n_start !== s0 || busy !== 1'b0 || disp_sel !== 1'b0) begin
      bad++;
      $display("FAIL post_reset_idle got starts=%0d busy=%0b ds=%0b want 0 0 0", n_start - s0, busy, disp_sel);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_async_reset();
    test_mul_bounce();
    test_div_zero();
    test_back_to_back();
    test_timeout();
    total++;
    if (sq.size() != 0 || rq.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain got starts_left=%0d results_left=%0d want 0 0", sq.size(), rq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
